// File: rtl/gpio_pad_pkg.sv
// -----------------------------------------------------------------------------
// gpio_pad_pkg
// Shared definitions for the GPIO pad controller:
//   - register offsets (word index taken from iomem_addr[4:2])
//   - output-driver release sequencer states
//   - group_mask(): the pins belonging to one release group
// -----------------------------------------------------------------------------
package gpio_pad_pkg;

   localparam logic [2:0] REG_DOUT  = 3'd0;
   localparam logic [2:0] REG_OE    = 3'd1;
   localparam logic [2:0] REG_PULL  = 3'd2;
   localparam logic [2:0] REG_IN    = 3'd3;
   localparam logic [2:0] REG_IEN   = 3'd4;
   localparam logic [2:0] REG_ISTAT = 3'd5;

   typedef enum logic [1:0] {
      HOLD  = 2'd0,
      STAGE = 2'd1,
      RUN   = 2'd2
   } seq_state_t;

   // Pins [g*group .. g*group+group-1], clipped to n_pins, so the last group
   // may be partial.
   function automatic logic [15:0] group_mask(input int n_pins, input int group,
                                              input int g);
      logic [15:0] m;
      m = '0;
      for (int i = 0; i < 16; i++) begin
         if ((i < n_pins) && ((i / group) == g)) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/gpio_pad_sync.sv
// -----------------------------------------------------------------------------
// gpio_pad_sync
// Two-flop synchroniser for a vector of asynchronous pad inputs, plus a
// one-cycle rising-edge pulse derived from the synchronised value.
// Ports:
//   clk     in   1      system clock
//   resetn  in   1      asynchronous active-low reset (all flops to 0)
//   d_async in   WIDTH  asynchronous pad inputs
//   q_sync  out  WIDTH  synchronised inputs
//   rise    out  WIDTH  q_sync=1 while its previous value was 0
// -----------------------------------------------------------------------------
module gpio_pad_sync
   import gpio_pad_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [WIDTH-1:0] d_async,
   output logic [WIDTH-1:0] q_sync,
   output logic [WIDTH-1:0] rise
);

   logic [WIDTH-1:0] meta_q, meta_d;
   logic [WIDTH-1:0] sync_q, sync_d;
   logic [WIDTH-1:0] prev_q, prev_d;

   always_comb begin
      meta_d = d_async;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         meta_q <= '0;
         sync_q <= '0;
         prev_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign q_sync = sync_q;
   assign rise   = sync_q & ~prev_q;

endmodule

// File: rtl/gpio_pad_ctrl.sv
// -----------------------------------------------------------------------------
// gpio_pad_ctrl
// Register-mapped controller for N_PINS bidirectional pads on the picorv32
// iomem bus. Drives pad A/EN/PUEN/PDEN from registers, synchronises pad Y,
// latches rising edges as interrupts and, after reset, releases output
// drivers group by group to limit simultaneous switching.
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   iomem_valid/ready      request (already address-decoded) / 1-cycle ack
//   iomem_wstrb            byte write strobes, 0 = read
//   iomem_addr             byte address, [4:2] selects the register
//   iomem_wdata/rdata      write data / read data (valid while ready=1)
//   pad_a, pad_en          pad output data / tristate (0 = drive)
//   pad_puen, pad_pden     pull-up / pull-down controls (0 = on)
//   pad_y                  asynchronous pad inputs
//   irq                    |(IRQ_STAT & IRQ_EN), registered
//   seq_done               all driver groups released
// -----------------------------------------------------------------------------
module gpio_pad_ctrl
   import gpio_pad_pkg::*;
#(
   parameter int          N_PINS       = 16,
   parameter int          GROUP        = 4,
   parameter int          HOLD_CYCLES  = 16,
   parameter int          STAGE_CYCLES = 8,
   parameter logic [15:0] PD_RST       = 16'hFFFF
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              iomem_valid,
   output logic              iomem_ready,
   input  logic [3:0]        iomem_wstrb,
   input  logic [4:0]        iomem_addr,
   input  logic [31:0]       iomem_wdata,
   output logic [31:0]       iomem_rdata,
   output logic [N_PINS-1:0] pad_a,
   output logic [N_PINS-1:0] pad_en,
   output logic [N_PINS-1:0] pad_puen,
   output logic [N_PINS-1:0] pad_pden,
   input  logic [N_PINS-1:0] pad_y,
   output logic              irq,
   output logic              seq_done
);

   localparam int N_GROUPS = (N_PINS + GROUP - 1) / GROUP;
   localparam int G_W      = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
   localparam int CNT_MAX  = (HOLD_CYCLES > STAGE_CYCLES) ? HOLD_CYCLES : STAGE_CYCLES;
   localparam int CNT_W    = $clog2(CNT_MAX + 1);

   typedef logic [N_PINS-1:0] pins_t;

   logic        ready_q, ready_d;
   logic [31:0] rdata_q, rdata_d;
   pins_t       dout_q, dout_d;
   pins_t       oe_q, oe_d;
   pins_t       pu_q, pu_d;
   pins_t       pd_q, pd_d;
   pins_t       ien_q, ien_d;
   pins_t       istat_q, istat_d;
   logic        irq_q, irq_d;

   seq_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [G_W-1:0]   grp_q, grp_d;
   pins_t            rel_q, rel_d;
   logic             seq_done_q, seq_done_d;

   pins_t pad_a_q, pad_a_d;
   pins_t pad_en_q, pad_en_d;
   pins_t pad_puen_q, pad_puen_d;
   pins_t pad_pden_q, pad_pden_d;

   pins_t       in_w, rise_w;
   logic        acc, wr;
   logic [2:0]  sel;
   logic [31:0] be32, rd_mux;
   pins_t       be_lo, be_hi, wd_lo, wd_hi;
   logic [15:0] grp_mask;
   logic        unused_bits;

   gpio_pad_sync #(.WIDTH(N_PINS)) u_sync (
      .clk     (clk),
      .resetn  (resetn),
      .d_async (pad_y),
      .q_sync  (in_w),
      .rise    (rise_w)
   );

   // Bus decode. A request is accepted only while ready is low, which gives
   // the mandatory idle cycle between back-to-back accesses.
   always_comb begin
      acc   = iomem_valid & ~ready_q;
      wr    = acc & (|iomem_wstrb);
      sel   = iomem_addr[4:2];
      be32  = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
               {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
      be_lo = be32[N_PINS-1:0];
      be_hi = be32[16 +: N_PINS];
      wd_lo = iomem_wdata[N_PINS-1:0];
      wd_hi = iomem_wdata[16 +: N_PINS];
   end

   // Read mux sees the pre-write register state.
   always_comb begin
      rd_mux = 32'h0;
      case (sel)
         REG_DOUT:  rd_mux = 32'(dout_q);
         REG_OE:    rd_mux = 32'(oe_q);
         REG_PULL:  rd_mux = {16'(pd_q), 16'(pu_q)};
         REG_IN:    rd_mux = 32'(in_w);
         REG_IEN:   rd_mux = 32'(ien_q);
         REG_ISTAT: rd_mux = 32'(istat_q);
         default:   rd_mux = 32'h0;
      endcase
   end

   always_comb begin
      ready_d = acc;
      rdata_d = acc ? rd_mux : 32'h0;
      dout_d  = dout_q;
      oe_d    = oe_q;
      pu_d    = pu_q;
      pd_d    = pd_q;
      ien_d   = ien_q;
      istat_d = istat_q;
      if (wr) begin
         case (sel)
            REG_DOUT:  dout_d  = (dout_q & ~be_lo) | (wd_lo & be_lo);
            REG_OE:    oe_d    = (oe_q   & ~be_lo) | (wd_lo & be_lo);
            REG_PULL: begin
               pu_d = (pu_q & ~be_lo) | (wd_lo & be_lo);
               pd_d = (pd_q & ~be_hi) | (wd_hi & be_hi);
            end
            REG_IEN:   ien_d   = (ien_q  & ~be_lo) | (wd_lo & be_lo);
            REG_ISTAT: istat_d = istat_q & ~(wd_lo & be_lo);
            default:   ;
         endcase
      end
      // Applied after the W1C so a new edge wins over a simultaneous clear.
      istat_d = istat_d | rise_w;
      irq_d   = |(istat_q & ien_q);
   end

   // Driver release sequencer: hold all drivers off, then OR one group into
   // rel_mask on entering STAGE and every STAGE_CYCLES after that.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      grp_d      = grp_q;
      rel_d      = rel_q;
      seq_done_d = seq_done_q;
      grp_mask   = group_mask(N_PINS, GROUP, int'(grp_q));
      case (state_q)
         HOLD: begin
            if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
               state_d = STAGE;
               cnt_d   = '0;
               grp_d   = '0;
               rel_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STAGE: begin
            if (cnt_q == '0) begin
               rel_d = rel_q | grp_mask[N_PINS-1:0];
               cnt_d = CNT_W'(STAGE_CYCLES - 1);
               if (grp_q == G_W'(N_GROUPS - 1)) begin
                  state_d    = RUN;
                  rel_d      = '1;
                  seq_done_d = 1'b1;
               end else begin
                  grp_d = grp_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RUN: begin
            rel_d      = '1;
            seq_done_d = 1'b1;
         end
         default: state_d = HOLD;
      endcase
   end

   // Pad outputs are registered; pull-up takes priority over pull-down.
   always_comb begin
      pad_a_d    = dout_q;
      pad_en_d   = ~(oe_q & rel_q);
      pad_puen_d = ~pu_q;
      pad_pden_d = ~(pd_q & ~pu_q);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ready_q    <= 1'b0;
         rdata_q    <= 32'h0;
         dout_q     <= '0;
         oe_q       <= '0;
         pu_q       <= '0;
         pd_q       <= PD_RST[N_PINS-1:0];
         ien_q      <= '0;
         istat_q    <= '0;
         irq_q      <= 1'b0;
         state_q    <= HOLD;
         cnt_q      <= '0;
         grp_q      <= '0;
         rel_q      <= '0;
         seq_done_q <= 1'b0;
         pad_a_q    <= '0;
         pad_en_q   <= '1;
         pad_puen_q <= '1;
         pad_pden_q <= ~PD_RST[N_PINS-1:0];
      end else begin
         ready_q    <= ready_d;
         rdata_q    <= rdata_d;
         dout_q     <= dout_d;
         oe_q       <= oe_d;
         pu_q       <= pu_d;
         pd_q       <= pd_d;
         ien_q      <= ien_d;
         istat_q    <= istat_d;
         irq_q      <= irq_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         grp_q      <= grp_d;
         rel_q      <= rel_d;
         seq_done_q <= seq_done_d;
         pad_a_q    <= pad_a_d;
         pad_en_q   <= pad_en_d;
         pad_puen_q <= pad_puen_d;
         pad_pden_q <= pad_pden_d;
      end
   end

   // Address byte-offset bits and, for narrow configurations, upper data
   // bits have no function.
   assign unused_bits = ^{iomem_addr[1:0], iomem_wdata, be32, grp_mask};

   assign iomem_ready = ready_q;
   assign iomem_rdata = rdata_q;
   assign pad_a       = pad_a_q;
   assign pad_en      = pad_en_q;
   assign pad_puen    = pad_puen_q;
   assign pad_pden    = pad_pden_q;
   assign irq         = irq_q;
   assign seq_done    = seq_done_q;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gpio_pad_ctrl
// Directed bench for gpio_pad_ctrl with default parameters: reset values,
// staged driver release, a table of bus accesses with expected read data and
// pad states, interrupt edge/W1C behaviour and reset in the middle of staging.
// -----------------------------------------------------------------------------
module tb_gpio_pad_ctrl;

   logic        clk;
   logic        resetn;
   logic        iomem_valid;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb;
   logic [4:0]  iomem_addr;
   logic [31:0] iomem_wdata;
   logic [31:0] iomem_rdata;
   logic [15:0] pad_a, pad_en, pad_puen, pad_pden, pad_y;
   logic        irq, seq_done;

   int n_vec  = 0;
   int n_fail = 0;
   int cyc;
   logic [31:0] r;

   typedef struct {
      logic [4:0]  addr;
      logic [3:0]  strb;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [15:0] a;
      logic [15:0] en;
      logic [15:0] puen;
      logic [15:0] pden;
   } vec_t;

   localparam int NV = 17;
   vec_t vt[NV];

   gpio_pad_ctrl dut (
      .clk         (clk),
      .resetn      (resetn),
      .iomem_valid (iomem_valid),
      .iomem_ready (iomem_ready),
      .iomem_wstrb (iomem_wstrb),
      .iomem_addr  (iomem_addr),
      .iomem_wdata (iomem_wdata),
      .iomem_rdata (iomem_rdata),
      .pad_a       (pad_a),
      .pad_en      (pad_en),
      .pad_puen    (pad_puen),
      .pad_pden    (pad_pden),
      .pad_y       (pad_y),
      .irq         (irq),
      .seq_done    (seq_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edges since the last reset release.
   always @(posedge clk or negedge resetn) begin
      if (!resetn) cyc <= 0;
      else         cyc <= cyc + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h want 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // One bus access; checks ready is high for exactly one cycle.
   task automatic bus(input logic [4:0] a, input logic [3:0] s,
                      input logic [31:0] d, output logic [31:0] rd);
      @(negedge clk);
      iomem_valid = 1'b1;
      iomem_addr  = a;
      iomem_wstrb = s;
      iomem_wdata = d;
      @(posedge clk); #1;
      chk("ready_hi", {31'b0, iomem_ready}, 32'd1);
      rd = iomem_rdata;
      iomem_valid = 1'b0;
      iomem_wstrb = 4'b0;
      @(posedge clk); #1;
      chk("ready_lo", {31'b0, iomem_ready}, 32'd0);
   endtask

   // pad_en with OE=FFFF, by edges since reset release.
   function automatic logic [15:0] exp_en(input int c);
      if (c <= 17)      return 16'hFFFF;
      else if (c <= 25) return 16'hFFF0;
      else if (c <= 33) return 16'hFF00;
      else if (c <= 41) return 16'hF000;
      else              return 16'h0000;
   endfunction

   task automatic stage_watch(input int last_cyc);
      while (cyc < last_cyc) begin
         @(posedge clk); #1;
         chk($sformatf("stage_en_c%0d", cyc), {16'h0, pad_en}, {16'h0, exp_en(cyc)});
         chk($sformatf("stage_done_c%0d", cyc), {31'b0, seq_done}, {31'b0, (cyc >= 41)});
      end
   endtask

   initial begin
      //            addr   strb     wdata          rdata          a        en       puen     pden
      vt[0]  = '{5'h00, 4'b0001, 32'h0000_1234, 32'h0000_0000, 16'h0034, 16'h0000, 16'hFFFF, 16'h0000};
      vt[1]  = '{5'h00, 4'b0000, 32'h0000_0000, 32'h0000_0034, 16'h0034, 16'h0000, 16'hFFFF, 16'h0000};
      vt[2]  = '{5'h00, 4'b1111, 32'hFFFF_A5C3, 32'h0000_0034, 16'hA5C3, 16'h0000, 16'hFFFF, 16'h0000};
      vt[3]  = '{5'h00, 4'b0000, 32'h0000_0000, 32'h0000_A5C3, 16'hA5C3, 16'h0000, 16'hFFFF, 16'h0000};
      vt[4]  = '{5'h04, 4'b0001, 32'h0000_00F0, 32'h0000_FFFF, 16'hA5C3, 16'h000F, 16'hFFFF, 16'h0000};
      vt[5]  = '{5'h04, 4'b0000, 32'h0000_0000, 32'h0000_FFF0, 16'hA5C3, 16'h000F, 16'hFFFF, 16'h0000};
      vt[6]  = '{5'h08, 4'b0011, 32'h0001_0001, 32'hFFFF_0000, 16'hA5C3, 16'h000F, 16'hFFFE, 16'h0001};
      vt[7]  = '{5'h08, 4'b0000, 32'h0000_0000, 32'hFFFF_0001, 16'hA5C3, 16'h000F, 16'hFFFE, 16'h0001};
      vt[8]  = '{5'h08, 4'b1100, 32'h0003_0000, 32'hFFFF_0001, 16'hA5C3, 16'h000F, 16'hFFFE, 16'hFFFD};
      vt[9]  = '{5'h08, 4'b0000, 32'h0000_0000, 32'h0003_0001, 16'hA5C3, 16'h000F, 16'hFFFE, 16'hFFFD};
      vt[10] = '{5'h0C, 4'b1111, 32'h0000_FFFF, 32'h0000_0000, 16'hA5C3, 16'h000F, 16'hFFFE, 16'hFFFD};
      vt[11] = '{5'h0C, 4'b0000, 32'h0000_0000, 32'h0000_0000, 16'hA5C3, 16'h000F, 16'hFFFE, 16'hFFFD};
      vt[12] = '{5'h18, 4'b1111, 32'hFFFF_FFFF, 32'h0000_0000, 16'hA5C3, 16'h000F, 16'hFFFE, 16'hFFFD};
      vt[13] = '{5'h1C, 4'b0000, 32'h0000_0000, 32'h0000_0000, 16'hA5C3, 16'h000F, 16'hFFFE, 16'hFFFD};
      vt[14] = '{5'h10, 4'b1111, 32'hFFFF_0001, 32'h0000_0000, 16'hA5C3, 16'h000F, 16'hFFFE, 16'hFFFD};
      vt[15] = '{5'h10, 4'b0000, 32'h0000_0000, 32'h0000_0001, 16'hA5C3, 16'h000F, 16'hFFFE, 16'hFFFD};
      vt[16] = '{5'h14, 4'b0000, 32'h0000_0000, 32'h0000_0000, 16'hA5C3, 16'h000F, 16'hFFFE, 16'hFFFD};

      resetn      = 1'b1;
      iomem_valid = 1'b0;
      iomem_wstrb = 4'b0;
      iomem_addr  = 5'h0;
      iomem_wdata = 32'h0;
      pad_y       = 16'h0;
      #2 resetn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pad_en",   {16'h0, pad_en},   32'h0000_FFFF);
      chk("rst_pad_pden", {16'h0, pad_pden}, 32'h0000_0000);
      chk("rst_pad_puen", {16'h0, pad_puen}, 32'h0000_FFFF);
      chk("rst_pad_a",    {16'h0, pad_a},    32'h0000_0000);
      chk("rst_irq",      {31'b0, irq},      32'd0);
      chk("rst_ready",    {31'b0, iomem_ready}, 32'd0);
      chk("rst_rdata",    iomem_rdata,       32'h0);
      chk("rst_seq_done", {31'b0, seq_done}, 32'd0);

      // Staged release with OE all ones.
      @(negedge clk) resetn = 1'b1;
      bus(5'h04, 4'b1111, 32'h0000_FFFF, r);
      stage_watch(50);

      // Register/pad vector table.
      for (int i = 0; i < NV; i++) begin
         bus(vt[i].addr, vt[i].strb, vt[i].wdata, r);
         chk($sformatf("vec%0d_rdata", i), r, vt[i].rdata);
         chk($sformatf("vec%0d_pad_a", i),    {16'h0, pad_a},    {16'h0, vt[i].a});
         chk($sformatf("vec%0d_pad_en", i),   {16'h0, pad_en},   {16'h0, vt[i].en});
         chk($sformatf("vec%0d_pad_puen", i), {16'h0, pad_puen}, {16'h0, vt[i].puen});
         chk($sformatf("vec%0d_pad_pden", i), {16'h0, pad_pden}, {16'h0, vt[i].pden});
      end

      // Master holding valid through the ack: one idle cycle, then a new ack.
      @(negedge clk);
      iomem_valid = 1'b1;
      iomem_addr  = 5'h00;
      iomem_wstrb = 4'b0;
      @(posedge clk); #1;
      chk("hold_ready1", {31'b0, iomem_ready}, 32'd1);
      chk("hold_rdata1", iomem_rdata, 32'h0000_A5C3);
      @(posedge clk); #1;
      chk("hold_idle", {31'b0, iomem_ready}, 32'd0);
      @(posedge clk); #1;
      chk("hold_ready2", {31'b0, iomem_ready}, 32'd1);
      iomem_valid = 1'b0;
      @(posedge clk); #1;
      chk("hold_ready3", {31'b0, iomem_ready}, 32'd0);

      // Rising edge on pin 0 with IRQ_EN[0]=1: irq four edges after pad_y.
      begin
         int lat;
         lat = 0;
         @(negedge clk) pad_y = 16'h0001;
         while (lat < 9) begin
            @(posedge clk); #1;
            lat++;
            if (irq) break;
         end
         chk("irq_latency", lat, 4);
      end
      chk("irq_set", {31'b0, irq}, 32'd1);
      bus(5'h0C, 4'b0000, 32'h0, r);
      chk("in_rd", r, 32'h0000_0001);
      bus(5'h14, 4'b0000, 32'h0, r);
      chk("istat_rd", r, 32'h0000_0001);
      bus(5'h14, 4'b0001, 32'h0000_0001, r);
      chk("w1c_irq_clr", {31'b0, irq}, 32'd0);
      bus(5'h14, 4'b0000, 32'h0, r);
      chk("istat_clr", r, 32'h0000_0000);

      // W1C of pin 1 landing on the same edge its rise is recorded.
      @(negedge clk) pad_y = 16'h0003;
      @(posedge clk);
      @(posedge clk); #1;
      bus(5'h14, 4'b0001, 32'h0000_0002, r);
      bus(5'h14, 4'b0000, 32'h0, r);
      chk("w1c_set_wins", r, 32'h0000_0002);
      chk("irq_masked", {31'b0, irq}, 32'd0);
      bus(5'h14, 4'b0001, 32'h0000_0002, r);
      bus(5'h14, 4'b0000, 32'h0, r);
      chk("w1c_plain", r, 32'h0000_0000);

      // Reset in the middle of staging (rel_mask = 00FF).
      @(negedge clk) resetn = 1'b0;
      @(negedge clk) resetn = 1'b1;
      bus(5'h04, 4'b1111, 32'h0000_FFFF, r);
      stage_watch(30);
      chk("mid_en_ff00", {16'h0, pad_en}, 32'h0000_FF00);
      #2 resetn = 1'b0;
      #1;
      chk("mid_rst_en", {16'h0, pad_en}, 32'h0000_FFFF);
      chk("mid_rst_done", {31'b0, seq_done}, 32'd0);
      @(negedge clk);
      @(negedge clk) resetn = 1'b1;
      bus(5'h04, 4'b1111, 32'h0000_FFFF, r);
      stage_watch(20);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
